// File: rtl/muldiv_seq.sv
// Sequential MIPS-style HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: 33 cycles busy (32 RUN + 1 FIX), divide-by-zero 1 cycle; Done_OUT pulses the cycle after FIX.
// Backpressure: Stall_OUT holds EXE while busy and it presents Start/MFHI/MFLO/MTHI/MTLO.
module muldiv_seq (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Start_IN,
    input  logic [1:0]  Op_IN,
    input  logic [31:0] OperandA_IN,
    input  logic [31:0] OperandB_IN,
    input  logic        WriteHI_IN,
    input  logic        WriteLO_IN,
    input  logic [31:0] WriteData_IN,
    input  logic        ReadHILO_IN,
    input  logic        Flush_IN,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT,
    output logic        Busy_OUT,
    output logic        Stall_OUT,
    output logic        Done_OUT,
    output logic        DivZero_OUT
);
    localparam logic [1:0] OP_MULT = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [1:0]  op;
    logic [31:0] mag_a, mag_b;
    logic        sign_a, sign_b;
    logic [4:0]  cnt;
    logic [63:0] acc;

    logic [31:0] start_mag_a, start_mag_b;
    logic        start_signed, start_div0;
    logic [32:0] mul_sum, div_top;
    logic [31:0] div_rem;
    logic        div_ge;
    logic [63:0] step_acc;
    logic [31:0] quo, rem;
    logic [63:0] fix_res;

    assign start_signed = ~Op_IN[0];
    assign start_mag_a  = (start_signed && OperandA_IN[31]) ? -OperandA_IN : OperandA_IN;
    assign start_mag_b  = (start_signed && OperandB_IN[31]) ? -OperandB_IN : OperandB_IN;
    assign start_div0   = Op_IN[1] && (OperandB_IN == 32'd0);

    // Divide keeps a 33-bit partial remainder window {acc[63:31]}; it never exceeds 2*divisor.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
        div_top  = acc[63:31];
        div_ge   = div_top >= {1'b0, mag_b};
        div_rem  = div_ge ? 32'(div_top - {1'b0, mag_b}) : div_top[31:0];
        step_acc = op[1] ? {div_rem, acc[30:0], div_ge} : {mul_sum, acc[31:1]};
    end

    always_comb begin
        quo     = acc[31:0];
        rem     = acc[63:32];
        fix_res = acc;
        if (DivZero_OUT) begin
            fix_res = acc;
        end else if (!op[1]) begin
            fix_res = (op == OP_MULT && (sign_a ^ sign_b)) ? -acc : acc;
        end else begin
            if (op == OP_DIV && (sign_a ^ sign_b)) quo = -quo;
            if (op == OP_DIV && sign_a)            rem = -rem;
            fix_res = {rem, quo};
        end
    end

    assign Busy_OUT  = (state != IDLE);
    assign Stall_OUT = Busy_OUT && (Start_IN || ReadHILO_IN || WriteHI_IN || WriteLO_IN);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            op          <= 2'd0;
            mag_a       <= 32'd0;
            mag_b       <= 32'd0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            cnt         <= 5'd0;
            acc         <= 64'd0;
            HI_OUT      <= 32'd0;
            LO_OUT      <= 32'd0;
            Done_OUT    <= 1'b0;
            DivZero_OUT <= 1'b0;
        end else begin
            Done_OUT <= 1'b0;
            if (Flush_IN) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start_IN) begin
                            op          <= Op_IN;
                            mag_a       <= start_mag_a;
                            mag_b       <= start_mag_b;
                            sign_a      <= OperandA_IN[31];
                            sign_b      <= OperandB_IN[31];
                            cnt         <= 5'd31;
                            DivZero_OUT <= start_div0;
                            if (start_div0) begin
                                acc   <= {OperandA_IN, 32'hFFFF_FFFF};
                                state <= FIX;
                            end else begin
                                acc   <= Op_IN[1] ? {32'd0, start_mag_a} : {32'd0, start_mag_b};
                                state <= RUN;
                            end
                        end else begin
                            if (WriteHI_IN) HI_OUT <= WriteData_IN;
                            if (WriteLO_IN) LO_OUT <= WriteData_IN;
                        end
                    end
                    RUN: begin
                        acc <= step_acc;
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) state <= FIX;
                    end
                    FIX: begin
                        HI_OUT   <= fix_res[63:32];
                        LO_OUT   <= fix_res[31:0];
                        Done_OUT <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table for the arithmetic, hand sequences for stall/flush/reset timing.
module tb_muldiv_seq;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        Start_IN = 1'b0;
    logic [1:0]  Op_IN = 2'd0;
    logic [31:0] OperandA_IN = 32'd0;
    logic [31:0] OperandB_IN = 32'd0;
    logic        WriteHI_IN = 1'b0;
    logic        WriteLO_IN = 1'b0;
    logic [31:0] WriteData_IN = 32'd0;
    logic        ReadHILO_IN = 1'b0;
    logic        Flush_IN = 1'b0;
    logic [31:0] HI_OUT, LO_OUT;
    logic        Busy_OUT, Stall_OUT, Done_OUT, DivZero_OUT;

    int checks = 0;
    int failures = 0;

    muldiv_seq dut (
        .CLK(CLK), .RESET(RESET), .Start_IN(Start_IN), .Op_IN(Op_IN),
        .OperandA_IN(OperandA_IN), .OperandB_IN(OperandB_IN),
        .WriteHI_IN(WriteHI_IN), .WriteLO_IN(WriteLO_IN), .WriteData_IN(WriteData_IN),
        .ReadHILO_IN(ReadHILO_IN), .Flush_IN(Flush_IN),
        .HI_OUT(HI_OUT), .LO_OUT(LO_OUT), .Busy_OUT(Busy_OUT), .Stall_OUT(Stall_OUT),
        .Done_OUT(Done_OUT), .DivZero_OUT(DivZero_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Start at a negedge, then watch a fixed 60-cycle window counting busy and done cycles.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output int done_cnt);
        busy_cyc = 0;
        done_cnt = 0;
        @(negedge CLK);
        Start_IN = 1'b1; Op_IN = op; OperandA_IN = a; OperandB_IN = b;
        @(negedge CLK);
        Start_IN = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (Busy_OUT) busy_cyc++;
            if (Done_OUT) done_cnt++;
            @(negedge CLK);
        end
    endtask

    vec_t vecs[12];
    int   busy_cyc, done_cnt, stall_bad, waited;
    logic [31:0] hi_keep, lo_keep;

    initial begin
        vecs[0]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[6]  = '{2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[7]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{2'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{2'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
        vecs[11] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

        // Reset state while RESET is held low with no clock edge required.
        #2;
        check("reset_hi", HI_OUT, 0);
        check("reset_lo", LO_OUT, 0);
        check("reset_busy", Busy_OUT, 0);
        check("reset_done", Done_OUT, 0);
        check("reset_dz", DivZero_OUT, 0);
        @(negedge CLK);
        RESET = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, busy_cyc, done_cnt);
            check($sformatf("vec%0d_hi", i), HI_OUT, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), LO_OUT, vecs[i].lo);
            check($sformatf("vec%0d_dz", i), DivZero_OUT, vecs[i].dz);
            check($sformatf("vec%0d_busy", i), busy_cyc, vecs[i].dz ? 1 : 33);
            check($sformatf("vec%0d_done", i), done_cnt, 1);
        end

        // MTHI/MTLO in IDLE, then MULTU 2x3 with MFHI pending throughout.
        @(negedge CLK);
        WriteHI_IN = 1'b1; WriteData_IN = 32'h0000_1234;
        @(negedge CLK);
        WriteHI_IN = 1'b0; WriteLO_IN = 1'b1; WriteData_IN = 32'h0000_ABCD;
        @(negedge CLK);
        WriteLO_IN = 1'b0;
        check("mthi", HI_OUT, 32'h1234);
        check("mtlo", LO_OUT, 32'hABCD);
        ReadHILO_IN = 1'b1;
        check("stall_idle", Stall_OUT, 0);
        Start_IN = 1'b1; Op_IN = 2'd1; OperandA_IN = 2; OperandB_IN = 3;
        @(negedge CLK);
        Start_IN = 1'b0;
        busy_cyc = 0; stall_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (Busy_OUT) begin
                busy_cyc++;
                if (!Stall_OUT) stall_bad++;
            end else if (Stall_OUT) stall_bad++;
            @(negedge CLK);
        end
        ReadHILO_IN = 1'b0;
        check("stall_busy_bad", stall_bad, 0);
        check("stall_busy_cyc", busy_cyc, 33);
        check("mul23_hi", HI_OUT, 0);
        check("mul23_lo", LO_OUT, 6);

        // Start with simultaneous MTHI: start wins, write dropped.
        WriteHI_IN = 1'b1; WriteData_IN = 32'hDEAD_BEEF;
        Start_IN = 1'b1; Op_IN = 2'd3; OperandA_IN = 9; OperandB_IN = 4;
        @(negedge CLK);
        WriteHI_IN = 1'b0; Start_IN = 1'b0;
        check("start_wins_busy", Busy_OUT, 1);
        check("start_wins_hi", HI_OUT, 0);
        repeat (40) @(negedge CLK);
        check("divu94_hi", HI_OUT, 1);
        check("divu94_lo", LO_OUT, 2);

        // Flush together with start in IDLE: start ignored.
        Start_IN = 1'b1; Flush_IN = 1'b1; Op_IN = 2'd1;
        @(negedge CLK);
        Start_IN = 1'b0; Flush_IN = 1'b0;
        check("flush_start_busy", Busy_OUT, 0);

        // Flush at RUN cycle 10.
        hi_keep = HI_OUT; lo_keep = LO_OUT;
        Start_IN = 1'b1; Op_IN = 2'd1; OperandA_IN = 32'h1111_1111; OperandB_IN = 32'h10;
        @(negedge CLK);
        Start_IN = 1'b0;
        repeat (9) @(negedge CLK);
        Flush_IN = 1'b1;
        @(negedge CLK);
        Flush_IN = 1'b0;
        check("flush_busy", Busy_OUT, 0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done_OUT || Busy_OUT) done_cnt++;
            @(negedge CLK);
        end
        check("flush_no_done", done_cnt, 0);
        check("flush_hi", HI_OUT, hi_keep);
        check("flush_lo", LO_OUT, lo_keep);

        // Divide-by-zero then reset pulse at RUN cycle 20, between clock edges.
        run_op(2'd3, 32'h7, 32'h0, busy_cyc, done_cnt);
        check("dz_set", DivZero_OUT, 1);
        Start_IN = 1'b1; Op_IN = 2'd1; OperandA_IN = 32'h55; OperandB_IN = 32'h3;
        @(negedge CLK);
        Start_IN = 1'b0;
        check("dz_cleared", DivZero_OUT, 0);
        repeat (19) @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check("rst_mid_hi", HI_OUT, 0);
        check("rst_mid_lo", LO_OUT, 0);
        check("rst_mid_busy", Busy_OUT, 0);
        #1 RESET = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done_OUT || Busy_OUT) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);

        // Back-to-back: new start in the Done cycle is taken with no bubble.
        Start_IN = 1'b1; Op_IN = 2'd1; OperandA_IN = 3; OperandB_IN = 4;
        @(negedge CLK);
        Start_IN = 1'b0;
        waited = 0;
        while (!Done_OUT && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        check("b2b_done_seen", Done_OUT, 1);
        check("b2b_first_lo", LO_OUT, 12);
        Start_IN = 1'b1; Op_IN = 2'd3; OperandA_IN = 20; OperandB_IN = 6;
        @(negedge CLK);
        Start_IN = 1'b0;
        check("b2b_busy", Busy_OUT, 1);
        repeat (40) @(negedge CLK);
        check("b2b_hi", HI_OUT, 2);
        check("b2b_lo", LO_OUT, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port CLK, input, 1, single clock, all state updates on posedge.
REQ-002 SHALL have port RESET, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port Start_IN, input, 1, start request from EXE.
REQ-004 SHALL have port Op_IN, input, 2, operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-005 SHALL have ports OperandA_IN and OperandB_IN, input, 32 each, multiplicand/dividend and multiplier/divisor.
REQ-006 SHALL have ports WriteHI_IN, WriteLO_IN (input, 1 each) and WriteData_IN (input, 32), for MTHI/MTLO.
REQ-007 SHALL have port ReadHILO_IN, input, 1, MFHI/MFLO pending in EXE.
REQ-008 SHALL have port Flush_IN, input, 1, abort of the in-flight operation.
REQ-009 SHALL have ports HI_OUT and LO_OUT, output, 32 each, architectural HI/LO registers.
REQ-010 SHALL have ports Busy_OUT (output, 1, operation in flight) and Stall_OUT (output, 1, combinational pipeline stall).
REQ-011 SHALL have ports Done_OUT (output, 1, one-cycle completion pulse) and DivZero_OUT (output, 1, sticky until next start).

Function
REQ-012 SHALL implement states IDLE, RUN, FIX; Busy_OUT=1 exactly when state is RUN or FIX.
REQ-013 In IDLE, Start_IN=1 at a posedge SHALL latch Op_IN, the operand magnitudes (signed ops: |x| with wrap, unsigned: raw), and both sign bits; SHALL load iteration counter=31; next state RUN.
REQ-014 DIV/DIVU with OperandB_IN=0 SHALL skip RUN: next state FIX directly, DivZero_OUT set.
REQ-015 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle on a 64-bit accumulator; counter decrements; after the counter==0 step, next state FIX.
REQ-016 FIX SHALL write HI/LO at its posedge and return to IDLE; Done_OUT SHALL be 1 for exactly the following cycle.
REQ-017 Multiply result: {HI,LO}=64-bit product, negated (two's complement, 64-bit) for MULT when operand signs differ.
REQ-018 Divide result: LO=quotient, HI=remainder; for DIV the quotient is negated if signs differ, the remainder takes the dividend's sign.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 (wrap, no exception).
REQ-020 Divide-by-zero SHALL give HI=OperandA_IN, LO=0xFFFFFFFF.
REQ-021 Latency: start posedge T; Busy_OUT high for 33 cycles (32 RUN + 1 FIX); new HI/LO visible after posedge T+33; Done_OUT high in cycle T+33..T+34; divide-by-zero: Busy 1 cycle, HI/LO visible after T+1.
REQ-022 Stall_OUT SHALL equal Busy_OUT AND (Start_IN OR ReadHILO_IN OR WriteHI_IN OR WriteLO_IN); Stall_OUT=0 in IDLE.
REQ-023 Start_IN, WriteHI_IN, WriteLO_IN while Busy_OUT=1 SHALL be ignored (EXE re-presents them once the stall clears).
REQ-024 In IDLE, WriteHI_IN/WriteLO_IN SHALL load WriteData_IN into HI/LO at the posedge, both if both asserted.
REQ-025 In IDLE, Start_IN together with WriteHI_IN/WriteLO_IN: Start SHALL win; the writes are dropped.
REQ-026 Flush_IN=1 at a posedge SHALL force IDLE, leave HI/LO unchanged, suppress Done_OUT, and not update DivZero_OUT; Flush_IN with Start_IN in IDLE: flush wins, start ignored.
REQ-027 A new start SHALL clear DivZero_OUT; Done_OUT SHALL be 0 in every cycle except REQ-016.
REQ-028 Back-to-back: Start_IN in the Done_OUT cycle (state IDLE) SHALL be accepted with no bubble.

Reset
REQ-029 RESET=0 SHALL immediately force state IDLE, HI_OUT=0, LO_OUT=0, Busy_OUT=0, Done_OUT=0, DivZero_OUT=0, counter=0, regardless of CLK.
REQ-030 RESET asserted mid-operation SHALL discard the operation; no Done_OUT after release.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001, one Done pulse.
REQ-032 MULT 0xFFFFFFFE (-2) x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 DIVU 5 / 0 -> Busy 1 cycle, HI=5, LO=0xFFFFFFFF, DivZero_OUT=1; next start clears it.
REQ-034 MTHI 0x1234 in IDLE then MULTU 2x3; ReadHILO_IN held during RUN -> Stall_OUT=1 every busy cycle, HI=0, LO=6 at end.
REQ-035 Flush_IN at RUN cycle 10 -> IDLE next cycle, HI/LO keep prior values, no Done pulse.
REQ-036 RESET pulsed low at RUN cycle 20 between clock edges -> outputs zero immediately, no Done after release.
